seq_sort: RTL
=============

Name: seq_sort

Overview:
- Parametrised, clocked successor to the combinational 4-input sorter.
- Sorts one vector of N unsigned W-bit words with an iterative odd-even transposition network, one compare-exchange phase per clock.
- Sort direction is selectable per vector.
- Valid/ready handshakes on input and output, so it can sit between a producer and a consumer that both apply backpressure.

Parameters:
W, 8, width of each element in bits (W ≥ 1).
N, 4, number of elements per vector (even, N ≥ 2).
CW, $clog2(N)+1, width of the internal phase counter.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data and descend are valid this cycle.
in_ready  output  1  block can accept a vector this cycle.
in_data  input  N*W  unsorted vector; element i is in bits [i*W +: W].
descend  input  1  0 = ascending, 1 = descending; sampled only on input accept.
out_valid  output  1  out_data holds a sorted vector.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  N*W  sorted vector; element i is in bits [i*W +: W].
busy  output  1  high in SORT and DONE states.

Behaviour:
- Reset (asynchronous, any time, including mid-sort):
  - State goes to IDLE; the element registers and the phase counter clear to 0.
  - Latched direction clears to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
  - A partially sorted vector is discarded, with no output.
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load in_data into the element registers, latch descend, clear the phase counter, go to SORT.
- SORT:
  - in_ready=0, out_valid=0.
  - Each cycle performs one phase p (p = phase counter value) on the element registers.
  - Even p: compare pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd p: compare pairs (1,2),(3,4),…,(N-3,N-2); elements 0 and N-1 hold.
  - Ascending: swap when e[lo] > e[hi].
  - Descending: swap when e[lo] < e[hi].
  - Equal values are never swapped.
  - All comparisons are unsigned and all pairs in a phase update simultaneously.
  - After the phase with p = N-1 completes, go to DONE. No early exit; latency is fixed.
- DONE:
  - out_valid=1; out_data is driven directly from the element registers and holds stable.
  - On out_ready=1: go to IDLE, out_valid drops the next cycle.
  - in_ready stays 0 in DONE; there is no overlap of output and input handshakes.
- Latency and throughput:
  - Accept on edge E0 → out_valid=1 after edge E_N (N cycles).
  - With out_ready held high, minimum spacing between accepts is N+2 cycles.
- Protocol:
  - in_valid while in_ready=0 is ignored.
  - Inputs are not required to stay stable after accept.
  - out_ready while out_valid=0 is ignored.
- Result:
  - Ascending: e[0] ≤ e[1] ≤ … ≤ e[N-1].
  - Descending: e[0] ≥ … ≥ e[N-1].
  - N phases are sufficient for any input permutation, including reverse-sorted.
- Boundary values:
  - Elements 0 and 2^W-1 compare correctly; there is no sign interpretation.
  - N=2: odd phases are no-ops.

Test Plan:
- Ascending: N=4, W=8, in 13,1,23,10 (e0..e3), descend=0, out_ready=1 → out_valid after exactly 4 cycles, out 1,10,13,23; in_ready high again the cycle after the output handshake.
- Descending, with backpressure: same data, descend=1, out_ready held low 10 cycles → out 23,13,10,1 held stable, out_valid=1, in_ready=0 and a new in_valid ignored throughout; out_ready=1 → IDLE.
- Duplicates and extremes: in 255,0,5,5 ascending → 0,5,5,255. Reverse-sorted 40,30,20,10 ascending → 10,20,30,40 after 4 cycles.
- Reset mid-sort: assert rst during phase 2 → out_data=0, out_valid=0, in_ready=1 immediately (asynchronous). Next vector 4,3,2,1 sorts correctly to 1,2,3,4.
- Parameter sweep: N=8, W=16, 200 random vectors with random descend and random out_ready → every output matches a reference sort, latency is always 8, and no vector is dropped or duplicated.

Source files
------------

// File: rtl/seq_sort.sv
// seq_sort: sequential sorter for one vector of N unsigned W-bit words.
// An odd-even transposition network runs one compare-exchange phase per
// clock for exactly N phases, so latency is fixed at N cycles. Sort direction
// is latched with each vector. The input and output sides each use a
// valid/ready handshake, and the two handshakes never overlap.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   in_valid/ready input handshake; in_data and descend are captured on accept
//   in_data        N*W unsorted vector, element i in [i*W +: W]
//   descend        0 = ascending, 1 = descending
//   out_valid/ready output handshake
//   out_data       N*W sorted vector, driven straight from the element registers
//   busy           high while sorting or holding a result

// One compare-exchange cell. When en_i is low both values pass through
// unchanged, so the parent can take either output without caring which
// cells are enabled in the current phase.
module seq_sort_cx #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         desc_i,
    input  logic         en_i,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);
    logic swap;

    // Strict comparisons, so equal values never swap.
    assign swap = en_i && (desc_i ? (a_i < b_i) : (a_i > b_i));
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;
endmodule

module seq_sort #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int CW = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic           descend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    localparam logic [CW-1:0] LAST_PHASE = CW'(N - 1);

    state_t                  state_q, state_d;
    logic [N-1:0][W-1:0]     elem_q, elem_d;
    logic [N-1:0][W-1:0]     net_elem;
    logic [N-2:0][W-1:0]     cx_lo, cx_hi;
    logic [CW-1:0]           phase_q, phase_d;
    logic                    desc_q, desc_d;

    // Cell i compares elements (i, i+1). It fires on phases whose parity
    // matches i: even cells on even phases, odd cells on odd phases.
    for (genvar i = 0; i < N - 1; i++) begin : g_cx
        localparam logic ODD = ((i % 2) == 1);
        seq_sort_cx #(.W(W)) u_cx (
            .a_i    (elem_q[i]),
            .b_i    (elem_q[i+1]),
            .desc_i (desc_q),
            .en_i   (phase_q[0] == ODD),
            .lo_o   (cx_lo[i]),
            .hi_o   (cx_hi[i])
        );
    end

    // Element j is the low side of cell j when that cell's parity matches
    // the phase, and otherwise the high side of cell j-1. The end elements
    // have no partner on one side and hold during that phase.
    for (genvar j = 0; j < N; j++) begin : g_el
        localparam logic ODD = ((j % 2) == 1);
        if (j == 0) begin : g_first
            assign net_elem[j] = (phase_q[0] == ODD) ? cx_lo[j] : elem_q[j];
        end else if (j == N - 1) begin : g_last
            assign net_elem[j] = (phase_q[0] == ODD) ? elem_q[j] : cx_hi[j-1];
        end else begin : g_mid
            assign net_elem[j] = (phase_q[0] == ODD) ? cx_lo[j] : cx_hi[j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
            phase_q <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            desc_q  <= desc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        phase_d   = phase_q;
        desc_d    = desc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    elem_d  = in_data;
                    desc_d  = descend;
                    phase_d = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                elem_d  = net_elem;
                phase_d = phase_q + 1'b1;
                // No early exit: N phases always run, keeping latency fixed.
                if (phase_q == LAST_PHASE) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = elem_q;
    assign busy     = (state_q != IDLE);
endmodule
